// File: rtl/preamble_inserter.sv
// rtl/preamble_inserter.sv - prepends short and long training preambles to every streamed packet
module preamble_inserter #(
    parameter int WIDTH        = 32,
    parameter int SHORT_PERIOD = 16,
    parameter int SHORT_LEN    = 160,
    parameter int LONG_PERIOD  = 64,
    parameter int LONG_CP      = 32,
    parameter logic [WIDTH*SHORT_PERIOD-1:0] SHORT_COEFFS = '0,
    parameter logic [WIDTH*LONG_PERIOD-1:0]  LONG_COEFFS  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             preamble_active
);

    // Long preamble: cyclic prefix followed by two full long symbols.
    localparam int LONG_LEN = LONG_CP + 2 * LONG_PERIOD;
    localparam int CNT_MAX  = (SHORT_LEN > LONG_LEN) ? SHORT_LEN : LONG_LEN;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TAB_MAX  = (SHORT_PERIOD > LONG_PERIOD) ? SHORT_PERIOD : LONG_PERIOD;
    localparam int IDX_W    = (TAB_MAX > 1) ? $clog2(TAB_MAX) : 1;

    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);
    localparam logic [IDX_W-1:0] SHORT_WRAP = IDX_W'(SHORT_PERIOD - 1);
    localparam logic [IDX_W-1:0] LONG_WRAP  = IDX_W'(LONG_PERIOD - 1);
    // The cyclic prefix is the tail of the long symbol, so the long table
    // index simply starts LONG_CP entries before the end and wraps modulo
    // LONG_PERIOD for the whole long section.
    localparam logic [IDX_W-1:0] LONG_START = IDX_W'((LONG_PERIOD - LONG_CP) % LONG_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHORT   = 2'd1,
        S_LONG    = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Running table index, kept alongside cnt to avoid a modulo on cnt.
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [WIDTH-1:0] short_sample;
    logic [WIDTH-1:0] long_sample;

    // State, sample counter and table index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Short table lookup by running index.
    always_comb begin
        short_sample = '0;
        for (int k = 0; k < SHORT_PERIOD; k++) begin
            if (idx_q == IDX_W'(k)) begin
                short_sample = SHORT_COEFFS[WIDTH*k +: WIDTH];
            end
        end
    end

    // Long table lookup by running index.
    always_comb begin
        long_sample = '0;
        for (int k = 0; k < LONG_PERIOD; k++) begin
            if (idx_q == IDX_W'(k)) begin
                long_sample = LONG_COEFFS[WIDTH*k +: WIDTH];
            end
        end
    end

    // Stream outputs: preamble from the tables, payload passed straight through.
    always_comb begin
        i_tready        = 1'b0;
        o_tdata         = '0;
        o_tlast         = 1'b0;
        o_tvalid        = 1'b0;
        preamble_active = 1'b0;
        case (state_q)
            S_SHORT: begin
                o_tvalid        = 1'b1;
                o_tdata         = short_sample;
                preamble_active = 1'b1;
            end
            S_LONG: begin
                o_tvalid        = 1'b1;
                o_tdata         = long_sample;
                preamble_active = 1'b1;
            end
            S_PAYLOAD: begin
                o_tvalid = i_tvalid;
                o_tdata  = i_tdata;
                o_tlast  = i_tlast;
                i_tready = o_tready;
            end
            default: begin
            end
        endcase
    end

    // Next state; preamble progress advances only on an output handshake so
    // everything holds still while downstream stalls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (i_tvalid) begin
                    state_d = S_SHORT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_SHORT: begin
                if (o_tready) begin
                    if (cnt_q == SHORT_LAST) begin
                        state_d = S_LONG;
                        cnt_d   = '0;
                        idx_d   = LONG_START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        idx_d = (idx_q == SHORT_WRAP) ? '0 : idx_q + 1'b1;
                    end
                end
            end
            S_LONG: begin
                if (o_tready) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = S_PAYLOAD;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        idx_d = (idx_q == LONG_WRAP) ? '0 : idx_q + 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_tvalid && o_tready && i_tlast) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_preamble_inserter.sv
// tb/tb_preamble_inserter.sv - randomized scoreboard bench for preamble_inserter
`timescale 1ns/1ps
module tb_preamble_inserter;

    localparam int W = 32;

    function automatic logic [31:0] tab(input int k);
        logic [31:0] r;
        r = {k[15:0], ~k[15:0]};
        return r;
    endfunction

    function automatic logic [W*16-1:0] mk_short();
        logic [W*16-1:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[W*k +: W] = tab(k);
        return r;
    endfunction

    function automatic logic [W*64-1:0] mk_long();
        logic [W*64-1:0] r;
        r = '0;
        for (int k = 0; k < 64; k++) r[W*k +: W] = tab(k);
        return r;
    endfunction

    localparam logic [W*16-1:0] SC = mk_short();
    localparam logic [W*64-1:0] LC = mk_long();

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  i_tdata;
    logic          i_tlast;
    logic          i_tvalid;
    logic          i_tready;
    logic [W-1:0]  o_tdata;
    logic          o_tlast;
    logic          o_tvalid;
    logic          o_tready;
    logic          preamble_active;

    preamble_inserter #(
        .WIDTH(W), .SHORT_PERIOD(16), .SHORT_LEN(160),
        .LONG_PERIOD(64), .LONG_CP(32),
        .SHORT_COEFFS(SC), .LONG_COEFFS(LC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .preamble_active(preamble_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int hs_count = 0;
    bit rnd_ready = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        p;
    } beat_t;

    beat_t exp_q[$];

    function automatic beat_t mk_beat(input logic [31:0] d, input logic l, input logic p);
        beat_t b;
        b.d = d; b.l = l; b.p = p;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Preamble from the rules: short symbol repeated 10 times, then the
    // last 32 long entries as prefix, then the long symbol twice.
    task automatic push_preamble();
        for (int k = 0; k < 160; k++) exp_q.push_back(mk_beat(tab(k % 16), 1'b0, 1'b1));
        for (int k = 0; k < 32; k++)  exp_q.push_back(mk_beat(tab(32 + k), 1'b0, 1'b1));
        for (int k = 0; k < 128; k++) exp_q.push_back(mk_beat(tab(k % 64), 1'b0, 1'b1));
    endtask

    task automatic send_packet(input int n, input bit gaps);
        logic [31:0] w[$];
        bit hs;
        int t;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        push_preamble();
        for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(w[i], (i == n - 1), 1'b0));
        for (int i = 0; i < n; i++) begin
            i_tdata  = w[i];
            i_tlast  = (i == n - 1);
            i_tvalid = 1'b1;
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 4000) begin
                @(negedge clk);
                hs = i_tready;
                @(posedge clk);
                #1;
                t++;
            end
            chk("input_handshake", {31'd0, hs}, 32'd1);
            if (gaps && i < n - 1 && $urandom_range(0, 1) == 1) begin
                i_tvalid = 1'b0;
                i_tlast  = 1'b0;
                i_tdata  = '0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle_inputs();
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = '0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 6000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #2;
        chk("idle_after_pkt", {29'd0, o_tvalid, i_tready, preamble_active}, 32'd0);
    endtask

    // Downstream ready: always high or a coin toss each cycle.
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Output checker against the expected beat queue, plus stall stability.
    initial begin
        logic        prev_v, prev_r, prev_l;
        logic [31:0] prev_d;
        beat_t       e;
        prev_v = 1'b0; prev_r = 1'b1; prev_l = 1'b0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v && !prev_r) begin
                    chk("stall_hold", {o_tvalid, o_tlast, o_tdata[29:0]}, {1'b1, prev_l, prev_d[29:0]});
                    chk("stall_data", o_tdata, prev_d);
                end
                if (o_tvalid) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", {31'd0, o_tvalid}, 32'd0);
                    end else begin
                        e = exp_q[0];
                        chk("o_tdata", o_tdata, e.d);
                        chk("o_tlast", {31'd0, o_tlast}, {31'd0, e.l});
                        chk("preamble_active", {31'd0, preamble_active}, {31'd0, e.p});
                        chk("i_tready", {31'd0, i_tready}, {31'd0, (!e.p) && o_tready});
                        if (o_tready) begin
                            void'(exp_q.pop_front());
                            hs_count++;
                        end
                    end
                end else begin
                    chk("quiet_preamble_flag", {31'd0, preamble_active}, 32'd0);
                end
                prev_v = o_tvalid;
                prev_r = o_tready;
                prev_d = o_tdata;
                prev_l = o_tlast;
            end
        end
    end

    initial begin
        int base;
        int t;
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("rst_o_tdata", o_tdata, 32'd0);
        chk("rst_o_tlast", {31'd0, o_tlast}, 32'd0);
        chk("rst_preamble", {31'd0, preamble_active}, 32'd0);
        chk("rst_i_tready", {31'd0, i_tready}, 32'd0);

        // Pin the model against hand-computed entries.
        push_preamble();
        chk("model_len", exp_q.size(), 320);
        chk("model_0", exp_q[0].d, 32'h0000ffff);
        chk("model_17", exp_q[17].d, 32'h0001fffe);
        chk("model_159", exp_q[159].d, 32'h000ffff0);
        chk("model_160", exp_q[160].d, 32'h0020ffdf);
        chk("model_192", exp_q[192].d, 32'h0000ffff);
        chk("model_319", exp_q[319].d, 32'h003fffc0);
        exp_q.delete();

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 4-sample packet, ready held high, with first-sample latency check.
        rnd_ready = 1'b0;
        fork
            send_packet(4, 1'b0);
            begin
                @(negedge clk);
                chk("lat_still_idle", {31'd0, o_tvalid}, 32'd0);
                @(negedge clk);
                chk("lat_first_valid", {31'd0, o_tvalid}, 32'd1);
                chk("lat_first_data", o_tdata, 32'h0000ffff);
            end
        join
        idle_inputs();
        drain();

        // Same packet shape with random downstream stalls and input gaps.
        rnd_ready = 1'b1;
        send_packet(4, 1'b1);
        idle_inputs();
        drain();

        // Back-to-back packets with i_tvalid held high between them.
        send_packet($urandom_range(1, 6), 1'b0);
        send_packet($urandom_range(1, 6), 1'b0);
        idle_inputs();
        drain();

        // Single-sample packet.
        rnd_ready = 1'b0;
        send_packet(1, 1'b0);
        idle_inputs();
        drain();

        // Reset at preamble sample 100, then a clean restart.
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;
        base = hs_count;
        push_preamble();
        i_tdata  = $urandom;
        i_tlast  = 1'b0;
        i_tvalid = 1'b1;
        t = 0;
        while (hs_count - base < 100 && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("reach_sample_100", hs_count - base, 100);
        @(posedge clk);
        #2;
        chk("sample_100_data", o_tdata, 32'h0004fffb);
        chk("sample_100_flag", {31'd0, preamble_active}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("async_rst_o_tdata", o_tdata, 32'd0);
        chk("async_rst_o_tlast", {31'd0, o_tlast}, 32'd0);
        chk("async_rst_preamble", {31'd0, preamble_active}, 32'd0);
        chk("async_rst_i_tready", {31'd0, i_tready}, 32'd0);
        idle_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, o_tvalid}, 32'd0);
        fork
            send_packet(3, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("restart_first_data", o_tdata, 32'h0000ffff);
            end
        join
        idle_inputs();
        drain();

        // A few random packets with random stalls and gaps.
        rnd_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            send_packet($urandom_range(1, 8), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                idle_inputs();
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        idle_inputs();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
